axistream_pktgen: RTL and testbench
===================================

# axistream_pktgen

Synthesizable AXI-Stream packet transmitter that drives the snoop input (sn_*) of the packet filter with deterministic, self-describing test packets. Software or a bench writes length, count and gap, pulses start, and the block emits that many packets, honouring TREADY backpressure. It replaces file-driven stimulus for on-board traffic generation and throughput measurement.

## Interface
- SN_FWD_DATA_WIDTH, 64: stream data width in bits; multiple of 8.
- MAX_PKT_BYTES, 2048: largest legal packet length; matches filter packet memory.
- KEEP_WIDTH, SN_FWD_DATA_WIDTH/8: byte lanes per beat (derived, not overridden).
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a burst; sampled only in IDLE.
- stop  in  1  level; request graceful end after the current packet.
- cfg_len  in  16  packet length in bytes.
- cfg_count  in  16  packets per burst.
- cfg_gap  in  8  idle cycles between packets (used only with PKTGEN_GAP_EN).
- sn_TDATA  out  SN_FWD_DATA_WIDTH  beat data; lane j = bits [8j+7:8j].
- sn_TKEEP  out  KEEP_WIDTH  byte-valid mask.
- sn_TVALID  out  1  beat valid.
- sn_TLAST  out  1  last beat of packet.
- sn_TREADY  in  1  downstream ready.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at burst end.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- pkts_sent  out  16  packets completed since the last accepted start.

## Operation
- States: IDLE, SEND, GAP.
- IDLE + start: if cfg_len==0, cfg_len>MAX_PKT_BYTES or cfg_count==0, pulse cfg_err and stay in IDLE. Otherwise latch cfg_*, clear pkts_sent and packet index n, then go to SEND.
- Beats per packet = ceil(cfg_len/KEEP_WIDTH). Byte k of packet n = (n + k) mod 256, where k is the byte offset in the packet and n is the packet index mod 256.
- TKEEP is all ones except on the last beat, where its low (cfg_len mod KEEP_WIDTH) bits are set; all ones if the remainder is 0. Unused lanes drive 0.
- A beat transfers when TVALID && TREADY. Once TVALID is high, TDATA, TKEEP and TLAST hold stable until the transfer.
- On the TLAST transfer, pkts_sent and n increment. Then:
  - if pkts_sent reaches cfg_count, or stop is high that cycle: go to IDLE and pulse done;
  - else if gap is enabled and cfg_gap>0: go to GAP;
  - else stay in SEND with the next packet.
- GAP counts cfg_gap cycles, then returns to SEND.
- stop never truncates a packet. stop seen in GAP goes to IDLE at once and pulses done.
- start while busy is ignored. Config changes while busy are ignored because the values are latched.
- pkts_sent wraps modulo 2^16.

## Timing
- Reset: every output is 0 and the state is IDLE. rst during a packet drops TVALID in the next cycle; the packet is abandoned.
- start at edge t: first beat has TVALID high from cycle t+1. All outputs are registered.
- With TREADY held high: one beat per cycle, no bubbles inside a packet.
- Without gap: the next packet's first beat follows the TLAST transfer in the next cycle.
- With gap G: TVALID is low for exactly G cycles between packets.
- done pulses in the cycle after the final TLAST transfer, when busy falls. cfg_err pulses in the cycle after start.
- TREADY low stalls the block indefinitely with no state change.

## Configuration
- PKTGEN_GAP_EN defined: GAP state and cfg_gap are active.
- Not defined: GAP state and gap counter are not built; cfg_gap is ignored; packets are always back-to-back.

## Structure
- Package axistream_pktgen_pkg holds:
  - state enum (IDLE/SEND/GAP);
  - function beats_for_len(len) and function last_keep(len);
  - localparams for the 16-bit counter widths.
- Sub-module axistream_pktgen_lanes: combinational; takes beat byte offset, packet index and keep mask, and produces TDATA. The FSM and counters stay in the top module.

## Test plan
- Length and count: cfg_len=20, cfg_count=2, TREADY=1 -> 3 beats per packet, last TKEEP=8'h0F; packet 0 beat 0 TDATA=64'h0706050403020100; packet 1 byte 0 = 8'h01; done 1 cycle after the 6th beat; pkts_sent=2.
- Backpressure: random TREADY (50%) with cfg_len=64, cfg_count=3 -> each beat's data held stable while stalled; 24 beats total; no lost or duplicate beats.
- Gap (macro defined): cfg_gap=5 -> TVALID low for exactly 5 cycles between packets. Macro undefined -> 0 cycles.
- Rejection: cfg_len=0, then cfg_len=2049, then cfg_count=0 -> cfg_err pulse for each; busy stays 0; sn_TVALID stays 0.
- Stop: cfg_count=100, stop asserted mid-packet 2 -> packet 2 completes with TLAST, then done; pkts_sent=3.
- Reset: rst pulsed mid-beat -> all outputs 0 the next cycle; a new start gives pkts_sent=0 and packet 0 data pattern.

Source files
------------

// File: rtl/axistream_pktgen_pkg.sv
// Shared types and helpers for the AXI-Stream packet generator.
// Holds the FSM state encoding, counter widths and the per-length
// beat/keep helpers used when a burst configuration is latched.
package axistream_pktgen_pkg;

  localparam int CNT_W      = 16;   // cfg_len / cfg_count / pkts_sent / beat index
  localparam int GAP_W      = 8;    // cfg_gap and the gap down-counter
  localparam int MAX_KEEP_W = 128;  // widest byte-lane mask the helpers can produce

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Number of beats needed to carry len bytes on a keep_w-lane bus.
  function automatic logic [CNT_W-1:0] beats_for_len(input logic [CNT_W-1:0] len,
                                                     input int keep_w);
    int beats;
    beats = (int'(len) + keep_w - 1) / keep_w;
    return beats[CNT_W-1:0];
  endfunction

  // TKEEP for the final beat: low (len mod keep_w) lanes, or all lanes when the
  // length is an exact multiple of the bus width.
  function automatic logic [MAX_KEEP_W-1:0] last_keep(input logic [CNT_W-1:0] len,
                                                      input int keep_w);
    logic [MAX_KEEP_W-1:0] mask;
    int rem;
    rem  = int'(len) % keep_w;
    mask = '0;
    for (int i = 0; i < MAX_KEEP_W; i++) begin
      if (rem == 0) mask[i] = (i < keep_w);
      else          mask[i] = (i < rem);
    end
    return mask;
  endfunction

endpackage

// File: rtl/axistream_pktgen_lanes.sv
// Byte-lane pattern generator: lane j carries (pkt_idx + byte_off + j) mod 256,
// so every byte of a packet encodes its own offset plus the packet index.
// Lanes with keep low are forced to zero.
module axistream_pktgen_lanes #(
  parameter int KEEP_WIDTH = 8
) (
  input  logic [7:0]              byte_off,
  input  logic [7:0]              pkt_idx,
  input  logic [KEEP_WIDTH-1:0]   keep,
  output logic [8*KEEP_WIDTH-1:0] data
);

  genvar gi;
  generate
    for (gi = 0; gi < KEEP_WIDTH; gi++) begin : g_lane
      // 8-bit wraparound gives the mod-256 pattern for free
      assign data[8*gi +: 8] = keep[gi] ? (pkt_idx + byte_off + 8'(gi)) : 8'd0;
    end
  endgenerate

endmodule

// File: rtl/axistream_pktgen.sv
// AXI-Stream packet generator feeding the filter snoop port.
// Emits cfg_count packets of cfg_len self-describing bytes per start pulse,
// honouring TREADY; every output is a flop.
// Optional feature: define PKTGEN_GAP_EN to build the inter-packet GAP state
// (cfg_gap idle cycles between packets); otherwise packets are back-to-back.
module axistream_pktgen
  import axistream_pktgen_pkg::*;
#(
  parameter  int SN_FWD_DATA_WIDTH = 64,
  parameter  int MAX_PKT_BYTES     = 2048,
  localparam int KEEP_WIDTH        = SN_FWD_DATA_WIDTH / 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic [15:0]                  cfg_len,
  input  logic [15:0]                  cfg_count,
  input  logic [7:0]                   cfg_gap,
  output logic [SN_FWD_DATA_WIDTH-1:0] sn_TDATA,
  output logic [KEEP_WIDTH-1:0]        sn_TKEEP,
  output logic                         sn_TVALID,
  output logic                         sn_TLAST,
  input  logic                         sn_TREADY,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_err,
  output logic [15:0]                  pkts_sent
);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [CNT_W-1:0]       last_beat_q, last_beat_d;
  logic [KEEP_WIDTH-1:0]  last_keep_q, last_keep_d;
  logic [7:0]             pkt_idx_q, pkt_idx_d;
  logic [CNT_W-1:0]       pkts_sent_q, pkts_sent_d;
  logic [CNT_W-1:0]       beat_q, beat_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic [KEEP_WIDTH-1:0]  tkeep_q, tkeep_d;
  logic [SN_FWD_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                   done_q, done_d;
  logic                   cfg_err_q, cfg_err_d;
  logic [7:0]             byte_off;
`ifdef PKTGEN_GAP_EN
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
`else
  logic                   unused_gap;
  assign unused_gap = ^cfg_gap;
`endif

  // Next-state logic: burst control, packet/beat counters and TVALID
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    last_beat_d = last_beat_q;
    last_keep_d = last_keep_q;
    pkt_idx_d   = pkt_idx_q;
    pkts_sent_d = pkts_sent_q;
    beat_d      = beat_q;
    tvalid_d    = tvalid_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
`ifdef PKTGEN_GAP_EN
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        tvalid_d = 1'b0;
        if (start) begin
          if (cfg_len == 16'd0 || cfg_len > 16'(MAX_PKT_BYTES) || cfg_count == 16'd0) begin
            cfg_err_d = 1'b1;
          end else begin
            count_d     = cfg_count;
            last_beat_d = beats_for_len(cfg_len, KEEP_WIDTH) - 16'd1;
            last_keep_d = KEEP_WIDTH'(last_keep(cfg_len, KEEP_WIDTH));
            pkts_sent_d = '0;
            pkt_idx_d   = '0;
            beat_d      = '0;
            tvalid_d    = 1'b1;
            state_d     = SEND;
`ifdef PKTGEN_GAP_EN
            gap_d       = cfg_gap;
`endif
          end
        end
      end
      SEND: begin
        if (tvalid_q && sn_TREADY) begin
          if (tlast_q) begin
            pkts_sent_d = pkts_sent_q + 16'd1;
            pkt_idx_d   = pkt_idx_q + 8'd1;
            beat_d      = '0;
            // stop only takes effect at a packet boundary, never mid-packet
            if (pkts_sent_d == count_q || stop) begin
              state_d  = IDLE;
              tvalid_d = 1'b0;
              done_d   = 1'b1;
            end
`ifdef PKTGEN_GAP_EN
            else if (gap_q != '0) begin
              state_d   = GAP;
              tvalid_d  = 1'b0;
              gap_cnt_d = gap_q;
            end
`endif
          end else begin
            beat_d = beat_q + 16'd1;
          end
        end
      end
      GAP: begin
`ifdef PKTGEN_GAP_EN
        if (stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (gap_cnt_q == 8'd1) begin
          state_d  = SEND;
          tvalid_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat attributes for the beat that will be presented next cycle
  always_comb begin
    tlast_d = tvalid_d && (beat_d == last_beat_d);
    tkeep_d = '0;
    if (tvalid_d) tkeep_d = tlast_d ? last_keep_q_sel() : '1;
  end

  function automatic logic [KEEP_WIDTH-1:0] last_keep_q_sel();
    return last_keep_d;
  endfunction

  assign byte_off = 8'(beat_d * 16'(KEEP_WIDTH));

  axistream_pktgen_lanes #(.KEEP_WIDTH(KEEP_WIDTH)) u_lanes (
    .byte_off (byte_off),
    .pkt_idx  (pkt_idx_d),
    .keep     (tkeep_d),
    .data     (tdata_d)
  );

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      last_beat_q <= '0;
      last_keep_q <= '0;
      pkt_idx_q   <= '0;
      pkts_sent_q <= '0;
      beat_q      <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tkeep_q     <= '0;
      tdata_q     <= '0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
`ifdef PKTGEN_GAP_EN
      gap_q       <= '0;
      gap_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      last_beat_q <= last_beat_d;
      last_keep_q <= last_keep_d;
      pkt_idx_q   <= pkt_idx_d;
      pkts_sent_q <= pkts_sent_d;
      beat_q      <= beat_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tkeep_q     <= tkeep_d;
      tdata_q     <= tdata_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
`ifdef PKTGEN_GAP_EN
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
`endif
    end
  end

  assign sn_TDATA  = tdata_q;
  assign sn_TKEEP  = tkeep_q;
  assign sn_TVALID = tvalid_q;
  assign sn_TLAST  = tlast_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign pkts_sent = pkts_sent_q;

endmodule

// File: tb/tb_axistream_pktgen.sv
// Self-checking bench for axistream_pktgen: directed bursts plus a
// specification-level model of the byte pattern, checked on every beat.
`timescale 1ns/1ps
module tb_axistream_pktgen;

  localparam int DW = 64;
  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          rst, start, stop, sn_TREADY;
  logic [15:0]   cfg_len, cfg_count;
  logic [7:0]    cfg_gap;
  logic [DW-1:0] sn_TDATA;
  logic [KW-1:0] sn_TKEEP;
  logic          sn_TVALID, sn_TLAST, busy, done, cfg_err;
  logic [15:0]   pkts_sent;

  always #5 clk = ~clk;

  axistream_pktgen #(.SN_FWD_DATA_WIDTH(DW), .MAX_PKT_BYTES(2048)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_len(cfg_len), .cfg_count(cfg_count), .cfg_gap(cfg_gap),
    .sn_TDATA(sn_TDATA), .sn_TKEEP(sn_TKEEP), .sn_TVALID(sn_TVALID),
    .sn_TLAST(sn_TLAST), .sn_TREADY(sn_TREADY),
    .busy(busy), .done(done), .cfg_err(cfg_err), .pkts_sent(pkts_sent)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Burst description handed from the driver to the model
  int arm_len = 0, arm_count = 0, arm_gap = 0, arm_seq = 0;
  int xfer_cnt = 0;

  // Model: what each beat must be, derived from byte k of packet n = (n+k) mod 256
  int seen_seq = 0;
  bit m_active = 0, exp_done = 0;
  int m_len, m_count, m_gap, m_n, m_beat, m_sent, gap_run;
  bit prev_valid = 0, prev_ready = 0, prev_last = 0;
  logic [DW-1:0] prev_data;
  logic [KW-1:0] prev_keep;

  always @(negedge clk) begin : monitor
    logic [DW-1:0] e_data;
    logic [KW-1:0] e_keep;
    bit e_last;
    int nb, k, e_gap;
    if (rst) begin
      m_active   = 0;
      exp_done   = 0;
      prev_valid = 0;
    end else begin
      chk("done_timing", {63'd0, done}, {63'd0, exp_done});
      if (exp_done) chk("busy_at_done", {63'd0, busy}, 64'd0);
      exp_done = 0;
      if (arm_seq != seen_seq) begin
        seen_seq = arm_seq;
        m_len = arm_len; m_count = arm_count; m_gap = arm_gap;
        m_n = 0; m_beat = 0; m_sent = 0; gap_run = 0;
        m_active = 1;
      end
      if (prev_valid && !prev_ready) begin
        chk("stall_valid", {63'd0, sn_TVALID}, 64'd1);
        chk("stall_data", sn_TDATA, prev_data);
        chk("stall_keep", {56'd0, sn_TKEEP}, {56'd0, prev_keep});
        chk("stall_last", {63'd0, sn_TLAST}, {63'd0, prev_last});
      end
      if (sn_TVALID && !m_active) chk("spurious_valid", {63'd0, sn_TVALID}, 64'd0);
      if (m_active && !sn_TVALID) gap_run++;
      if (sn_TVALID && sn_TREADY && m_active) begin
        e_data = '0;
        e_keep = '0;
        nb = (m_len + KW - 1) / KW;
        for (int j = 0; j < KW; j++) begin
          k = m_beat * KW + j;
          if (k < m_len) begin
            e_keep[j] = 1'b1;
            e_data[8*j +: 8] = 8'((m_n + k) % 256);
          end
        end
        e_last = (m_beat == nb - 1);
        chk("beat_data", sn_TDATA, e_data);
        chk("beat_keep", {56'd0, sn_TKEEP}, {56'd0, e_keep});
        chk("beat_last", {63'd0, sn_TLAST}, {63'd0, e_last});
`ifdef PKTGEN_GAP_EN
        e_gap = m_gap;
`else
        e_gap = 0;
`endif
        if (m_beat == 0 && m_n > 0) chk("gap_len", 64'(gap_run), 64'(e_gap));
        gap_run = 0;
        xfer_cnt++;
        $display("[TB] beat pkt=%0d beat=%0d data=%h keep=%h last=%b",
                 m_n, m_beat, sn_TDATA, sn_TKEEP, sn_TLAST);
        if (e_last) begin
          m_sent++;
          m_n++;
          m_beat = 0;
          if (m_sent == m_count || stop) begin
            exp_done = 1;
            m_active = 0;
          end
        end else begin
          m_beat++;
        end
      end
      prev_valid = sn_TVALID;
      prev_ready = sn_TREADY;
      prev_data  = sn_TDATA;
      prev_keep  = sn_TKEEP;
      prev_last  = sn_TLAST;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic arm(input int len, input int count, input int gap);
    cfg_len   = 16'(len);
    cfg_count = 16'(count);
    cfg_gap   = 8'(gap);
    arm_len   = len;
    arm_count = count;
    arm_gap   = gap;
    arm_seq++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < budget) begin
      step(1);
      cycles++;
    end
    chk("done_reached", {63'd0, done}, 64'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tvalid"}, {63'd0, sn_TVALID}, 64'd0);
    chk({tag, "_tdata"}, sn_TDATA, 64'd0);
    chk({tag, "_tkeep"}, {56'd0, sn_TKEEP}, 64'd0);
    chk({tag, "_tlast"}, {63'd0, sn_TLAST}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_cfg_err"}, {63'd0, cfg_err}, 64'd0);
    chk({tag, "_pkts_sent"}, {48'd0, pkts_sent}, 64'd0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int cyc, x0;
    int rej_len[3]   = '{0, 2049, 20};
    int rej_count[3] = '{1, 1, 0};
    rst = 1'b1; start = 1'b0; stop = 1'b0; sn_TREADY = 1'b1;
    cfg_len = '0; cfg_count = '0; cfg_gap = '0;
    step(3);
    chk_all_zero("reset");
    rst = 1'b0;
    step(1);

    // Length/count: 20 bytes -> 3 beats, last keep 0F
    $display("[TB] burst len=20 count=2");
    arm(20, 2, 0);
    pulse_start();
    chk("p0b0_valid", {63'd0, sn_TVALID}, 64'd1);
    chk("p0b0_data", sn_TDATA, 64'h0706050403020100);
    chk("p0b0_busy", {63'd0, busy}, 64'd1);
    step(2);
    chk("p0b2_data", sn_TDATA, 64'h0000000013121110);
    chk("p0b2_keep", {56'd0, sn_TKEEP}, 64'h0F);
    chk("p0b2_last", {63'd0, sn_TLAST}, 64'd1);
    step(1);
    chk("p1b0_data", sn_TDATA, 64'h0807060504030201);
    step(2);
    chk("p1b2_data", sn_TDATA, 64'h0000000014131211);
    step(1);
    chk("len_done", {63'd0, done}, 64'd1);
    chk("len_busy", {63'd0, busy}, 64'd0);
    chk("len_pkts", {48'd0, pkts_sent}, 64'd2);
    step(1);
    chk("len_done_pulse", {63'd0, done}, 64'd0);

    // Backpressure: random TREADY, 3 x 64 bytes = 24 beats
    $display("[TB] burst len=64 count=3 random ready");
    x0 = xfer_cnt;
    arm(64, 3, 0);
    pulse_start();
    cyc = 0;
    while (done !== 1'b1 && cyc < 400) begin
      sn_TREADY = 1'($urandom_range(0, 1));
      step(1);
      cyc++;
    end
    chk("bp_done", {63'd0, done}, 64'd1);
    chk("bp_beats", 64'(xfer_cnt - x0), 64'd24);
    chk("bp_pkts", {48'd0, pkts_sent}, 64'd3);
    sn_TREADY = 1'b1;
    step(2);

    // Gap: 3 x 2-beat packets with cfg_gap=5
    $display("[TB] burst len=16 count=3 gap=5");
    arm(16, 3, 5);
    pulse_start();
    wait_done(100, cyc);
`ifdef PKTGEN_GAP_EN
    chk("gap_total_cycles", 64'(cyc), 64'd16);
`else
    chk("gap_total_cycles", 64'(cyc), 64'd6);
`endif
    step(2);

    // Rejection of illegal configurations
    for (int i = 0; i < 3; i++) begin
      $display("[TB] reject len=%0d count=%0d", rej_len[i], rej_count[i]);
      cfg_len = 16'(rej_len[i]);
      cfg_count = 16'(rej_count[i]);
      pulse_start();
      chk("rej_cfg_err", {63'd0, cfg_err}, 64'd1);
      chk("rej_busy", {63'd0, busy}, 64'd0);
      chk("rej_tvalid", {63'd0, sn_TVALID}, 64'd0);
      step(1);
      chk("rej_cfg_err_pulse", {63'd0, cfg_err}, 64'd0);
    end

    // Stop mid-packet 2 of a long burst
    $display("[TB] burst len=20 count=100 stop in packet 2");
    arm(20, 100, 0);
    pulse_start();
    step(7);
    stop = 1'b1;
    wait_done(50, cyc);
    chk("stop_cycles", 64'(cyc), 64'd2);
    chk("stop_pkts", {48'd0, pkts_sent}, 64'd3);
    stop = 1'b0;
    step(2);

    // Reset in the middle of a packet, then a fresh burst
    $display("[TB] reset mid-packet");
    arm(64, 5, 0);
    pulse_start();
    step(2);
    rst = 1'b1;
    step(1);
    chk_all_zero("midrst");
    rst = 1'b0;
    arm(20, 1, 0);
    pulse_start();
    chk("rst_new_data", sn_TDATA, 64'h0706050403020100);
    chk("rst_new_pkts", {48'd0, pkts_sent}, 64'd0);
    wait_done(20, cyc);
    chk("rst_new_done_pkts", {48'd0, pkts_sent}, 64'd1);
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
